// File: rtl/ysyx_22050550_lsu_queue_if.sv
// Bundle of every handshake/bus signal around the LSU.
//   req_*    : EX -> LSU memory request (valid/ready)
//   resp_*   : LSU -> WB response (valid/ready)
//   cache_*  : LSU -> D-cache request, cache_dataok pulses on completion
//   ar/r/aw/w/b : AXI-style device channels
// Modports:
//   master : the LSU itself (drives cache/device requests and the response)
//   slave  : the surroundings (pipeline, D-cache, device bus)
interface ysyx_22050550_lsu_queue_if #(
  parameter int unsigned XLEN = 64
);
  localparam int unsigned NB = XLEN / 8;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [2:0]      req_func3;
  logic            req_rd;
  logic            req_wr;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            resp_err;

  logic            cache_valid;
  logic            cache_op;
  logic [XLEN-1:0] cache_addr;
  logic [XLEN-1:0] cache_wdata;
  logic [NB-1:0]   cache_wmask;
  logic [XLEN-1:0] cache_data;
  logic            cache_dataok;

  logic            ar_valid;
  logic            ar_ready;
  logic [XLEN-1:0] ar_addr;
  logic [2:0]      ar_size;
  logic            r_valid;
  logic            r_ready;
  logic [XLEN-1:0] r_data;

  logic            aw_valid;
  logic            aw_ready;
  logic [XLEN-1:0] aw_addr;
  logic [2:0]      aw_size;
  logic            w_valid;
  logic            w_ready;
  logic [XLEN-1:0] w_data;
  logic [NB-1:0]   w_strb;
  logic            b_valid;
  logic            b_ready;

  modport master (
    input  req_valid, req_addr, req_wdata, req_func3, req_rd, req_wr,
    output req_ready,
    output resp_valid, resp_data, resp_err,
    input  resp_ready,
    output cache_valid, cache_op, cache_addr, cache_wdata, cache_wmask,
    input  cache_data, cache_dataok,
    output ar_valid, ar_addr, ar_size, r_ready,
    input  ar_ready, r_valid, r_data,
    output aw_valid, aw_addr, aw_size, w_valid, w_data, w_strb, b_ready,
    input  aw_ready, w_ready, b_valid
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_func3, req_rd, req_wr,
    input  req_ready,
    input  resp_valid, resp_data, resp_err,
    output resp_ready,
    input  cache_valid, cache_op, cache_addr, cache_wdata, cache_wmask,
    output cache_data, cache_dataok,
    input  ar_valid, ar_addr, ar_size, r_ready,
    output ar_ready, r_valid, r_data,
    input  aw_valid, aw_addr, aw_size, w_valid, w_data, w_strb, b_ready,
    output aw_ready, w_ready, b_valid
  );
endinterface

// File: rtl/ysyx_22050550_lsu_queue.sv
// Load/store unit between EX and WB.
// Accepts one memory op per req handshake, routes it by addr[31:28] to the D-cache (PMEM_TAG)
// or to the AXI-style device port, aligns store data/mask and load data by byte offset,
// sign/zero-extends loads by func3 and returns a registered response with an error flag
// (misaligned access or device timeout).
// Ports:
//   clock : single clock
//   reset : synchronous, active-high; abandons any transaction in flight
//   bus   : ysyx_22050550_lsu_queue_if.master (request, response, cache and device channels)
module ysyx_22050550_lsu_queue #(
  parameter int unsigned XLEN        = 64,
  parameter logic [3:0]  PMEM_TAG    = 4'h8,
  parameter int unsigned DEV_TIMEOUT = 255
) (
  input logic                       clock,
  input logic                       reset,
  ysyx_22050550_lsu_queue_if.master bus
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned TW   = $clog2(DEV_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StCache, StAr, StR, StAww, StB, StResp} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [OFFW-1:0] off;
  logic [2:0]      op_func3;
  logic            is_load;

  // Request decode, evaluated on the accept cycle straight from the request inputs
  logic [1:0]      req_size;
  logic [OFFW-1:0] req_off;
  logic            req_misaligned;
  logic [NB-1:0]   req_mask;
  logic [XLEN-1:0] req_wdata_sh;
  logic            req_is_pmem;

  always_comb begin
    req_size       = bus.req_func3[1:0];
    req_off        = bus.req_addr[OFFW-1:0];
    req_misaligned = (req_off & OFFW'((4'd1 << req_size) - 4'd1)) != '0;
    req_mask       = ~({NB{1'b1}} << (4'd1 << req_size));
    req_mask       = req_mask << req_off;
    req_wdata_sh   = bus.req_wdata << {req_off, 3'b000};
    req_is_pmem    = bus.req_addr[31:28] == PMEM_TAG;
  end

  // Load data path: shared by the cache and device returns
  logic [XLEN-1:0] load_raw;
  logic [XLEN-1:0] load_sh;
  logic [XLEN-1:0] lo_mask;
  logic            load_sign;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    load_raw = (state == StCache) ? bus.cache_data : bus.r_data;
    load_sh  = load_raw >> {off, 3'b000};
    unique case (op_func3[1:0])
      2'd0:    begin lo_mask = XLEN'(64'hFF);        load_sign = load_sh[7];  end
      2'd1:    begin lo_mask = XLEN'(64'hFFFF);      load_sign = load_sh[15]; end
      2'd2:    begin lo_mask = XLEN'(64'hFFFF_FFFF); load_sign = load_sh[31]; end
      default: begin lo_mask = '1;                   load_sign = 1'b0;        end
    endcase
    load_ext = (load_sh & lo_mask) | ((load_sign && !op_func3[2]) ? ~lo_mask : '0);
    // func3 3'b111 has no defined load; hand back the word as fetched
    if (op_func3 == 3'b111) load_ext = load_raw;
  end

  logic dev_wait;
  logic timeout;
  logic aw_fin;
  logic w_fin;

  always_comb begin
    dev_wait = (state == StAr) || (state == StR) || (state == StAww) || (state == StB);
    timeout  = dev_wait && (timer == TW'(DEV_TIMEOUT - 1));
    aw_fin   = !bus.aw_valid || bus.aw_ready;
    w_fin    = !bus.w_valid || bus.w_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= StIdle;
      timer           <= '0;
      off             <= '0;
      op_func3        <= '0;
      is_load         <= 1'b0;
      bus.req_ready   <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_data   <= '0;
      bus.resp_err    <= 1'b0;
      bus.cache_valid <= 1'b0;
      bus.cache_op    <= 1'b0;
      bus.cache_addr  <= '0;
      bus.cache_wdata <= '0;
      bus.cache_wmask <= '0;
      bus.ar_valid    <= 1'b0;
      bus.ar_addr     <= '0;
      bus.ar_size     <= '0;
      bus.r_ready     <= 1'b0;
      bus.aw_valid    <= 1'b0;
      bus.aw_addr     <= '0;
      bus.aw_size     <= '0;
      bus.w_valid     <= 1'b0;
      bus.w_data      <= '0;
      bus.w_strb      <= '0;
      bus.b_ready     <= 1'b0;
    end else if (timeout) begin
      // Abort wins over any handshake landing in the same cycle
      bus.ar_valid   <= 1'b0;
      bus.r_ready    <= 1'b0;
      bus.aw_valid   <= 1'b0;
      bus.w_valid    <= 1'b0;
      bus.b_ready    <= 1'b0;
      bus.resp_valid <= 1'b1;
      bus.resp_data  <= '0;
      bus.resp_err   <= 1'b1;
      state          <= StResp;
    end else begin
      if (dev_wait) timer <= timer + 1'b1;
      unique case (state)
        StIdle: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            op_func3      <= bus.req_func3;
            off           <= req_off;
            is_load       <= bus.req_rd;
            if (!bus.req_rd && !bus.req_wr) begin
              bus.resp_valid <= 1'b1;
              bus.resp_data  <= '0;
              bus.resp_err   <= 1'b0;
              state          <= StResp;
            end else if (req_misaligned) begin
              bus.resp_valid <= 1'b1;
              bus.resp_data  <= '0;
              bus.resp_err   <= 1'b1;
              state          <= StResp;
            end else if (req_is_pmem) begin
              bus.cache_valid <= 1'b1;
              bus.cache_op    <= !bus.req_rd;
              bus.cache_addr  <= bus.req_addr;
              bus.cache_wdata <= req_wdata_sh;
              bus.cache_wmask <= bus.req_rd ? '0 : req_mask;
              state           <= StCache;
            end else if (bus.req_rd) begin
              bus.ar_valid <= 1'b1;
              bus.ar_addr  <= bus.req_addr;
              bus.ar_size  <= {1'b0, req_size};
              timer        <= '0;
              state        <= StAr;
            end else begin
              bus.aw_valid <= 1'b1;
              bus.aw_addr  <= bus.req_addr;
              bus.aw_size  <= {1'b0, req_size};
              bus.w_valid  <= 1'b1;
              bus.w_data   <= req_wdata_sh;
              bus.w_strb   <= req_mask;
              timer        <= '0;
              state        <= StAww;
            end
          end
        end
        StCache: begin
          if (bus.cache_dataok) begin
            bus.cache_valid <= 1'b0;
            bus.resp_valid  <= 1'b1;
            bus.resp_data   <= is_load ? load_ext : '0;
            bus.resp_err    <= 1'b0;
            state           <= StResp;
          end
        end
        StAr: begin
          if (bus.ar_ready) begin
            bus.ar_valid <= 1'b0;
            bus.r_ready  <= 1'b1;
            state        <= StR;
          end
        end
        StR: begin
          if (bus.r_valid) begin
            bus.r_ready    <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= load_ext;
            bus.resp_err   <= 1'b0;
            state          <= StResp;
          end
        end
        StAww: begin
          if (bus.aw_valid && bus.aw_ready) bus.aw_valid <= 1'b0;
          if (bus.w_valid && bus.w_ready) bus.w_valid <= 1'b0;
          if (aw_fin && w_fin) begin
            bus.b_ready <= 1'b1;
            state       <= StB;
          end
        end
        StB: begin
          if (bus.b_valid) begin
            bus.b_ready    <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b0;
            state          <= StResp;
          end
        end
        StResp: begin
          // Back to IDLE with req_ready already high; no accept in the handshake cycle itself
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule
